// File: rtl/div_clk_mon_pkg.sv
// Shared types for the divided-clock monitor.
// State encoding and fault codes reported on fault_code.
package div_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_SHORT = 2'b01;
    localparam logic [1:0] FC_LONG  = 2'b10;
    localparam logic [1:0] FC_STUCK = 2'b11;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus edge register for an async level input.
// Produces one-cycle rise/fall strobes; fall can be disabled.
module sync_edge_det #(
    parameter bit FALL_EN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // s1/s2 resolve metastability, s3 holds the previous settled level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = FALL_EN ? (~s2_q & s3_q) : 1'b0;

endmodule

// File: rtl/div_clk_monitor.sv
// Divided-clock monitor: edge ticks, period measurement, lock/fault FSM.
// Optional macro DIV_CLK_MON_FALL_EN: fall ticks and half-period timing.
module div_clk_monitor
    import div_clk_mon_pkg::*;
#(
    parameter int unsigned EXP_HALF = 3000001,
    parameter int unsigned TOL      = 16,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 25
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk_in,
    input  logic             fault_clr,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             fault,
    output logic [1:0]       fault_code
);

`ifdef DIV_CLK_MON_FALL_EN
    localparam bit          FALL_EN = 1'b1;
    localparam int unsigned EXP_P   = EXP_HALF;
    localparam int unsigned TOL_P   = TOL;
`else
    localparam bit          FALL_EN = 1'b0;
    localparam int unsigned EXP_P   = 2 * EXP_HALF;
    localparam int unsigned TOL_P   = 2 * TOL;
`endif

    localparam int unsigned LO_I = (EXP_P > TOL_P) ? EXP_P - TOL_P : 0;
    localparam int unsigned GW   = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W:0]   LO      = (CNT_W+1)'(LO_I);
    localparam logic [CNT_W:0]   HI      = (CNT_W+1)'(EXP_P + TOL_P);
    localparam logic [CNT_W:0]   STUCK   = (CNT_W+1)'(2 * EXP_P);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             rise, fall, edge_s;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W:0]   meas;
    logic             in_tol, is_short, is_long, stuck;
    state_e           state_q, state_d;
    logic [GW-1:0]    good_q, good_d;
    logic [1:0]       code_q, code_d;
    logic             tick_rise_q, tick_fall_q;
    logic             locked_q, fault_q;

    sync_edge_det #(
        .FALL_EN(FALL_EN)
    ) u_sync (
        .clk_i (clk_in),
        .rst_ni(rst),
        .d_i   (div_clk_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    // fall is constant 0 when only rising edges are counted
    assign edge_s   = rise | fall;
    assign meas     = {1'b0, hcnt_q} + (CNT_W+1)'(1);
    assign in_tol   = (meas >= LO) && (meas <= HI);
    assign is_short = meas < LO;
    assign is_long  = meas > HI;
    assign stuck    = !edge_s && (meas == STUCK);

    // Interval counter and measurement capture; the IDLE edge is partial
    always_comb begin
        hcnt_d = hcnt_q;
        half_d = half_q;
        if (edge_s) begin
            hcnt_d = '0;
            if (state_q != IDLE) begin
                half_d = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
            end
        end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    // Lock/fault next state; an edge always takes priority over stuck
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (edge_s) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (edge_s && in_tol) begin
                    if (good_q == GW'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                end else if (edge_s || stuck) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                if (edge_s && is_short) begin
                    state_d = FAULT;
                    code_d  = FC_SHORT;
                end else if (edge_s && is_long) begin
                    state_d = FAULT;
                    code_d  = FC_LONG;
                end else if (stuck) begin
                    state_d = FAULT;
                    code_d  = FC_STUCK;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                    code_d  = FC_NONE;
                end
            end
        endcase
    end

    // State, datapath and registered output decodes
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            good_q      <= '0;
            code_q      <= FC_NONE;
            hcnt_q      <= '0;
            half_q      <= '0;
            tick_rise_q <= 1'b0;
            tick_fall_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            code_q      <= code_d;
            hcnt_q      <= hcnt_d;
            half_q      <= half_d;
            tick_rise_q <= rise;
            tick_fall_q <= fall;
            locked_q    <= (state_d == LOCKED);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign tick_rise   = tick_rise_q;
    assign tick_fall   = tick_fall_q;
    assign half_period = half_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Randomised bench for div_clk_monitor against an interval-based model.
// Works with or without DIV_CLK_MON_FALL_EN defined.
module tb_div_clk_monitor;

    localparam int EXP_HALF = 10;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 25;
    localparam int MAXC     = 16384;

`ifdef DIV_CLK_MON_FALL_EN
    localparam bit FALL = 1'b1;
    localparam int EXPV = EXP_HALF;
    localparam int TOLV = TOL;
`else
    localparam bit FALL = 1'b0;
    localparam int EXPV = 2 * EXP_HALF;
    localparam int TOLV = 2 * TOL;
`endif

    localparam int S_IDLE = 0;
    localparam int S_ACQ  = 1;
    localparam int S_LOCK = 2;
    localparam int S_FLT  = 3;

    logic             clk_in = 1'b0;
    logic             rst = 1'b0;
    logic             div_clk_in = 1'b0;
    logic             fault_clr = 1'b0;
    logic             tick_rise, tick_fall, locked, fault;
    logic [CNT_W-1:0] half_period;
    logic [1:0]       fault_code;

    div_clk_monitor #(
        .EXP_HALF(EXP_HALF),
        .TOL     (TOL),
        .LOCK_CNT(LOCK_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .div_clk_in (div_clk_in),
        .fault_clr  (fault_clr),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .half_period(half_period),
        .locked     (locked),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk_in = ~clk_in;

    // clk_in edges since reset release; level driven for index k is sampled at edge k
    int cyc;
    always @(posedge clk_in or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    bit lvl [MAXC];
    bit fcs [MAXC];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    // Reference model: intervals between counted edges in sample indices
    int m_st, m_good, m_code, m_last, m_half;
    bit m_have, m_tr, m_tf;

    always @(negedge clk_in) begin : cmp
        int c, m, meas;
        bit er, ef, cnt, stk;
        if (!rst) begin
            m_st   = S_IDLE;
            m_good = 0;
            m_code = 0;
            m_last = 0;
            m_have = 0;
            m_half = 0;
        end else begin
            c = cyc;
            if (c < MAXC) begin
                m  = c - 2;
                er = 0;
                ef = 0;
                if (m >= 1) begin
                    er = lvl[m] & ~lvl[m-1];
                    ef = ~lvl[m] & lvl[m-1];
                end
                cnt  = FALL ? (er | ef) : er;
                meas = m - m_last;
                stk  = !cnt && m_have && (meas == 2 * EXPV);
                m_tr = er;
                m_tf = FALL ? ef : 1'b0;
                if (cnt && m_st != S_IDLE) m_half = meas;
                case (m_st)
                    S_IDLE: if (cnt) begin
                        m_st   = S_ACQ;
                        m_good = 0;
                    end
                    S_ACQ: begin
                        if (cnt && meas >= EXPV - TOLV && meas <= EXPV + TOLV) begin
                            m_good++;
                            if (m_good == LOCK_CNT) m_st = S_LOCK;
                        end else if (cnt || stk) begin
                            m_good = 0;
                        end
                    end
                    S_LOCK: begin
                        if (cnt && meas < EXPV - TOLV) begin
                            m_st = S_FLT; m_code = 1;
                        end else if (cnt && meas > EXPV + TOLV) begin
                            m_st = S_FLT; m_code = 2;
                        end else if (stk) begin
                            m_st = S_FLT; m_code = 3;
                        end
                    end
                    default: if (fcs[c]) begin
                        m_st   = S_ACQ;
                        m_good = 0;
                        m_code = 0;
                    end
                endcase
                if (cnt) begin
                    m_last = m;
                    m_have = 1;
                end
                chk("tick_rise", int'(tick_rise), int'(m_tr));
                chk("tick_fall", int'(tick_fall), int'(m_tf));
                chk("half_period", int'(half_period), m_half);
                chk("locked", int'(locked), int'(m_st == S_LOCK));
                chk("fault", int'(fault), int'(m_st == S_FLT));
                chk("fault_code", int'(fault_code), m_code);
            end
        end
    end

    bit lv = 1'b0;
    int t_cnt = 0;

    task automatic put(input bit v, input bit clr);
        @(posedge clk_in);
        #2;
        div_clk_in = v;
        fault_clr  = clr;
        if (cyc + 1 < MAXC) begin
            lvl[cyc+1] = v;
            fcs[cyc+1] = clr;
        end
    endtask

    task automatic wave(input int n, input int clr_at);
        lv = ~lv;
        for (int i = 0; i < n; i++) begin
            put(lv, i == clr_at);
            if (i == 0 && (FALL || lv)) t_cnt = cyc;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick_rise"}, int'(tick_rise), 0);
        chk({tag, "_tick_fall"}, int'(tick_fall), 0);
        chk({tag, "_half"}, int'(half_period), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_code"}, int'(fault_code), 0);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        lvl[0] = 1'b0;
        lv = ~lv; put(lv, 1'b0);
        lv = ~lv; put(lv, 1'b0);
        put(lv, 1'b0);
        @(posedge clk_in);
        #2;
        rst = 1'b1;
    endtask

    initial begin : drv
        int t0, lat, t_seen, r, h, ca;
        lvl[0] = 1'b0;
        put(1'b1, 1'b0);
        chk_zero("rst");
        put(1'b0, 1'b0);
        put(1'b1, 1'b0);
        put(1'b0, 1'b0);
        lv = 1'b0;
        @(posedge clk_in);
        #2;
        rst = 1'b1;

        // first rising edge: tick latency, no measurement
        lv = 1'b1;
        put(lv, 1'b0);
        t0    = cyc;
        t_cnt = t0;
        lat   = -1;
        for (int i = 1; i < EXP_HALF; i++) begin
            put(lv, 1'b0);
            if (lat < 0 && tick_rise) lat = cyc - t0;
        end
        chk("tick_latency", lat, 3);
        chk("first_edge_no_meas", int'(half_period), 0);
        chk("idle_not_locked", int'(locked), 0);

        repeat (11) wave(EXP_HALF, -1);
        chk("lock_acquired", int'(locked), 1);
        chk("nominal_period", int'(half_period), EXPV);

        wave(13, -1);
        wave(EXP_HALF, -1);
        wave(EXP_HALF, -1);
        chk("long_fault", int'(fault), 1);
        chk("long_code", int'(fault_code), 2);
        chk("long_unlocked", int'(locked), 0);
        repeat (4) wave(EXP_HALF, -1);
        chk("fault_sticky", int'(fault), 1);
        chk("code_frozen", int'(fault_code), 2);

        wave(EXP_HALF, 3);
        repeat (12) wave(EXP_HALF, -1);
        chk("relock_after_clr", int'(locked), 1);
        chk("code_cleared", int'(fault_code), 0);

        wave(7, -1);
        wave(EXP_HALF, -1);
        wave(EXP_HALF, -1);
        chk("short_code", int'(fault_code), 1);

        wave(EXP_HALF, 3);
        repeat (12) wave(EXP_HALF, -1);
        wave(9, -1);
        wave(11, -1);
        wave(9, -1);
        wave(11, -1);
        wave(EXP_HALF, -1);
        wave(EXP_HALF, -1);
        chk("tolerated_locked", int'(locked), 1);

        t_seen = -1;
        repeat (70) begin
            put(lv, 1'b0);
            if (t_seen < 0 && fault) t_seen = cyc;
        end
        chk("stuck_code", int'(fault_code), 3);
        chk("stuck_timing", t_seen - t_cnt, 2 * EXPV + 3);
        wave(EXP_HALF, 3);

        for (int i = 0; i < 250; i++) begin
            if (i == 100) do_reset();
            r = $urandom_range(0, 99);
            if (r < 75)      h = $urandom_range(EXP_HALF - 1, EXP_HALF + 1);
            else if (r < 84) h = $urandom_range(5, 8);
            else if (r < 93) h = $urandom_range(12, 15);
            else             h = 50;
            ca = ($urandom_range(0, 5) == 0) ? $urandom_range(0, h - 1) : -1;
            wave(h, ca);
        end
        repeat (5) put(lv, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
